lvds_rx_deframer: RTL and testbench
===================================

LVDS_RX_DEFRAMER -- requirements
Module: lvds_rx_deframer

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames at a fixed phase required to enter LOCKED (legal range 1..15).
REQ-002 SHALL have parameter LOSS_FRAMES, default 3: consecutive bad frames in LOCKED that force a return to HUNT (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_d  input  2  one DDR symbol pair per clk; rx_d[0] is the earlier bit on the line.
REQ-006 SHALL have port i_clear_err  input  1  synchronous clear of o_err_cnt.
REQ-007 SHALL have port o_i  output  13  I sample of the last good data frame.
REQ-008 SHALL have port o_q  output  13  Q sample of the last good data frame.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse; o_i/o_q were updated this cycle.
REQ-010 SHALL have port o_eom  output  1  one-cycle pulse; an end-of-message frame was received.
REQ-011 SHALL have port o_locked  output  1  high while the FSM is in LOCKED.
REQ-012 SHALL have port o_err_cnt  output  8  saturating count of bad frames seen in LOCKED.

Function
REQ-013 SHALL shift every clk: sr[31:0] <= {sr[29:0], rx_d[0], rx_d[1]}.
REQ-014 SHALL classify sr combinationally as follows.
- IDLE: sr == 0.
- SYNC: sr[31:30]==2'b10, sr[15:14]==2'b01, sr[0]==0.
- DATA: SYNC and sr[16]==1; I = sr[29:17], Q = sr[13:1].
- EOM: SYNC, sr[16]==0, sr[29:17]==0, sr[13:1]==0.
- BAD: anything that is not IDLE, DATA or EOM.
REQ-015 SHALL keep a 4-bit phase counter that increments every clk and wraps 15->0; a frame is evaluated only when phase==15, except in HUNT.
REQ-016 SHALL implement states HUNT, VERIFY and LOCKED; the state is HUNT after reset.
REQ-017 HUNT SHALL evaluate every clk; on DATA or EOM: phase<=0 and good_cnt<=1; next state LOCKED if LOCK_FRAMES==1, else VERIFY; no output pulse.
REQ-018 VERIFY at phase==15, DATA or EOM: good_cnt increments; on reaching LOCK_FRAMES the state goes to LOCKED and this frame is output per REQ-019/020.
- VERIFY at phase==15, BAD or IDLE: return to HUNT; o_err_cnt unchanged.
REQ-019 LOCKED at phase==15, DATA: register o_i/o_q, pulse o_valid, clear bad_cnt.
REQ-020 LOCKED at phase==15, EOM: pulse o_eom, o_valid stays low, o_i/o_q hold, clear bad_cnt, stay LOCKED.
REQ-021 LOCKED at phase==15, IDLE: go to HUNT with no error increment (transmitter idle).
REQ-022 LOCKED at phase==15, BAD: increment bad_cnt and o_err_cnt; when bad_cnt reaches LOSS_FRAMES, go to HUNT and clear bad_cnt.
REQ-023 All outputs SHALL be registered; o_valid/o_eom SHALL assert exactly one clk after the cycle in which sr holds the complete frame.
REQ-024 Good frames in LOCKED SHALL produce pulses spaced exactly 16 clk apart.
REQ-025 o_err_cnt SHALL saturate at 255; i_clear_err SHALL take priority over a simultaneous increment (result 0).
REQ-026 o_locked SHALL rise in the same cycle as the first LOCKED-state pulse and fall one clk after the HUNT-entry decision.

Reset
REQ-027 Reset asserted at any time, including mid-frame in LOCKED, SHALL asynchronously clear all of the following to 0, with state = HUNT:
- sr, phase, good_cnt, bad_cnt
- o_i, o_q, o_valid, o_eom, o_locked, o_err_cnt
REQ-028 After reset deasserts, the first possible lock SHALL require a fresh HUNT detection.

Verification
REQ-029 Stream of DATA frames (I=0x0ABC, Q=0x1234) at a 5-symbol offset -> o_locked high and first o_valid on the 2nd frame with o_i=0x0ABC, o_q=0x1234; subsequent o_valid every 16 clk.
REQ-030 While locked, send frame {2'b10, 14'b0, 2'b01, 14'b0} -> one o_eom pulse; o_valid low; o_i/o_q retain 0x0ABC/0x1234.
REQ-031 Locked; corrupt sr[31:30] in 2 consecutive frames, then a good frame -> o_err_cnt=2, o_locked stays high; 3 consecutive corruptions -> o_err_cnt=5, o_locked low after the 3rd.
REQ-032 Locked; drive rx_d=0 for 40 clk -> HUNT, o_locked low, o_err_cnt unchanged, no pulses.
REQ-033 Force 300 bad frames across repeated relocks -> o_err_cnt holds 255; i_clear_err coincident with a bad frame -> o_err_cnt=0.
REQ-034 Assert reset 7 clk into a locked frame -> all outputs 0 immediately (asynchronous); after release, no o_valid until LOCK_FRAMES good frames have been received.

Source files
------------

// File: rtl/lvds_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : lvds_rx_deframer
// Purpose  : Recovers 32-bit I/Q frames from a 2-bit DDR LVDS stream with
//            hunt / verify / locked alignment tracking and error counting.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_rx_deframer #(
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rx_d,
    input  logic        i_clear_err,
    output logic [12:0] o_i,
    output logic [12:0] o_q,
    output logic        o_valid,
    output logic        o_eom,
    output logic        o_locked,
    output logic [7:0]  o_err_cnt
);

    localparam logic [3:0] c_lock_n = 4'(LOCK_FRAMES);
    localparam logic [3:0] c_loss_n = 4'(LOSS_FRAMES);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_sr;
    logic [3:0]  r_phase;
    logic [3:0]  r_good_cnt;
    logic [3:0]  r_bad_cnt;

    logic [3:0]  w_phase_nxt;
    logic [3:0]  w_good_nxt;
    logic [3:0]  w_bad_nxt;
    logic [3:0]  w_good_inc;
    logic [3:0]  w_bad_inc;
    logic        w_valid_nxt;
    logic        w_eom_nxt;
    logic        w_load_iq;
    logic        w_err_inc;

    logic        w_sync;
    logic        w_data;
    logic        w_eom;
    logic        w_idle;
    logic        w_good;
    logic        w_eval;

    assign w_sync = (r_sr[31:30] == 2'b10) && (r_sr[15:14] == 2'b01) && !r_sr[0];
    assign w_data = w_sync && r_sr[16];
    assign w_eom  = w_sync && !r_sr[16] && (r_sr[29:17] == 13'd0) && (r_sr[13:1] == 13'd0);
    assign w_idle = (r_sr == 32'd0);
    assign w_good = w_data || w_eom;
    assign w_eval = (r_phase == 4'd15);

    assign w_good_inc = r_good_cnt + 4'd1;
    assign w_bad_inc  = r_bad_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 4'd1;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_valid_nxt = 1'b0;
        w_eom_nxt   = 1'b0;
        w_load_iq   = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            HUNT: begin
                // Any good frame in the window re-aligns the frame phase.
                if (w_good) begin
                    w_phase_nxt = 4'd0;
                    w_good_nxt  = 4'd1;
                    w_bad_nxt   = 4'd0;
                    w_state_nxt = (c_lock_n == 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (w_eval) begin
                    if (w_good) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_lock_n) begin
                            w_state_nxt = LOCKED;
                            w_valid_nxt = w_data;
                            w_load_iq   = w_data;
                            w_eom_nxt   = w_eom;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (w_eval) begin
                    if (w_data) begin
                        w_valid_nxt = 1'b1;
                        w_load_iq   = 1'b1;
                        w_bad_nxt   = 4'd0;
                    end else if (w_eom) begin
                        w_eom_nxt = 1'b1;
                        w_bad_nxt = 4'd0;
                    end else if (w_idle) begin
                        // Idle transmitter is a loss of signal, not a line error.
                        w_state_nxt = HUNT;
                        w_bad_nxt   = 4'd0;
                    end else begin
                        w_err_inc = 1'b1;
                        if (w_bad_inc == c_loss_n) begin
                            w_state_nxt = HUNT;
                            w_bad_nxt   = 4'd0;
                        end else begin
                            w_bad_nxt = w_bad_inc;
                        end
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= HUNT;
            r_sr       <= 32'd0;
            r_phase    <= 4'd0;
            r_good_cnt <= 4'd0;
            r_bad_cnt  <= 4'd0;
            o_i        <= 13'd0;
            o_q        <= 13'd0;
            o_valid    <= 1'b0;
            o_eom      <= 1'b0;
            o_locked   <= 1'b0;
            o_err_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= {r_sr[29:0], rx_d[0], rx_d[1]};
            r_phase    <= w_phase_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            o_valid    <= w_valid_nxt;
            o_eom      <= w_eom_nxt;
            o_locked   <= (w_state_nxt == LOCKED);
            if (w_load_iq) begin
                o_i <= r_sr[29:17];
                o_q <= r_sr[13:1];
            end
            if (i_clear_err) begin
                o_err_cnt <= 8'd0;
            end else if (w_err_inc && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_rx_deframer
// Purpose  : Directed stimulus for lvds_rx_deframer checked every cycle
//            against a frame-level reference model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_rx_deframer;

    localparam int LF = 2;
    localparam int LS = 3;

    localparam int K_IDLE = 0;
    localparam int K_DATA = 1;
    localparam int K_EOM  = 2;
    localparam int K_BAD  = 3;

    // I=0x0ABC Q=0x1234, same with corrupted header, end-of-message, I=0x1FFF Q=0x0001
    localparam logic [31:0] FR_AB  = 32'h9579_6468;
    localparam logic [31:0] FR_BAD = 32'hD579_6468;
    localparam logic [31:0] FR_EOM = 32'h8000_4000;
    localparam logic [31:0] FR_FF  = 32'hBFFF_4002;

    logic        clk;
    logic        reset;
    logic [1:0]  rx_d;
    logic        i_clear_err;
    logic [12:0] o_i;
    logic [12:0] o_q;
    logic        o_valid;
    logic        o_eom;
    logic        o_locked;
    logic [7:0]  o_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_eom = 0;
    int v0;

    lvds_rx_deframer #(.LOCK_FRAMES(LF), .LOSS_FRAMES(LS)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_d        (rx_d),
        .i_clear_err (i_clear_err),
        .o_i         (o_i),
        .o_q         (o_q),
        .o_valid     (o_valid),
        .o_eom       (o_eom),
        .o_locked    (o_locked),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_kind(input logic [31:0] w);
        logic sync;
        sync = (w[31:30] == 2'b10) && (w[15:14] == 2'b01) && !w[0];
        if (w == 32'd0) return K_IDLE;
        if (sync && w[16]) return K_DATA;
        if (sync && (w[29:17] == 13'd0) && (w[13:1] == 13'd0)) return K_EOM;
        return K_BAD;
    endfunction

    // Reference model: mode 0 searching, 1 confirming, 2 tracking.
    // m_age counts cycles since the last alignment; frames complete every 16.
    logic [31:0] m_sr = '0;
    int          m_mode = 0;
    int          m_age = 0;
    int          m_good = 0;
    int          m_bad = 0;
    int          mk;
    bit          m_bump;
    logic [12:0] m_i = '0;
    logic [12:0] m_q = '0;
    logic        m_valid = 1'b0;
    logic        m_eom = 1'b0;
    logic        m_locked = 1'b0;
    int          m_err = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sr = '0; m_mode = 0; m_age = 0; m_good = 0; m_bad = 0;
            m_i = '0; m_q = '0; m_valid = 1'b0; m_eom = 1'b0; m_locked = 1'b0; m_err = 0;
        end else begin
            mk = frame_kind(m_sr);
            m_bump = 1'b0;
            m_valid = 1'b0;
            m_eom = 1'b0;
            if (m_mode == 0) begin
                m_age = m_age + 1;
                if (mk == K_DATA || mk == K_EOM) begin
                    m_age = 0; m_good = 1; m_bad = 0;
                    m_mode = (LF == 1) ? 2 : 1;
                end
            end else if ((m_age % 16) == 15) begin
                m_age = m_age + 1;
                if (m_mode == 1) begin
                    if (mk == K_DATA || mk == K_EOM) begin
                        m_good = m_good + 1;
                        if (m_good >= LF) m_mode = 2;
                    end else begin
                        m_mode = 0;
                    end
                end else if (mk == K_IDLE) begin
                    m_mode = 0; m_bad = 0;
                end else if (mk == K_BAD) begin
                    m_bump = 1'b1;
                    m_bad = m_bad + 1;
                    if (m_bad >= LS) begin m_mode = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
                if (m_mode == 2 && mk == K_DATA) begin
                    m_valid = 1'b1; m_i = m_sr[29:17]; m_q = m_sr[13:1];
                end
                if (m_mode == 2 && mk == K_EOM) m_eom = 1'b1;
            end else begin
                m_age = m_age + 1;
            end
            if (i_clear_err) m_err = 0;
            else if (m_bump && m_err < 255) m_err = m_err + 1;
            m_locked = (m_mode == 2);
            m_sr = {m_sr[29:0], rx_d[0], rx_d[1]};
        end
    end

    always @(negedge clk) begin
        check("valid",   32'(o_valid),   32'(m_valid));
        check("eom",     32'(o_eom),     32'(m_eom));
        check("locked",  32'(o_locked),  32'(m_locked));
        check("err_cnt", 32'(o_err_cnt), 32'(m_err));
        check("i",       32'(o_i),       32'(m_i));
        check("q",       32'(o_q),       32'(m_q));
        if (o_valid === 1'b1) n_valid++;
        if (o_eom === 1'b1) n_eom++;
    end

    task automatic send_pair(input logic [1:0] p);
        rx_d = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send_pair(2'b00);
    endtask

    // clr_first raises i_clear_err on the edge that closes the previous frame.
    task automatic send_frame(input logic [31:0] f, input logic clr_first);
        for (int k = 0; k < 16; k++) begin
            i_clear_err = (k == 0) ? clr_first : 1'b0;
            send_pair({f[30 - 2*k], f[31 - 2*k]});
        end
        i_clear_err = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx_d = 2'b00;
        i_clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(o_locked), 32'd0);
        check("rst_err",    32'(o_err_cnt), 32'd0);
        check("rst_i",      32'(o_i), 32'd0);
        check("kind_ab",    32'(frame_kind(FR_AB)), 32'(K_DATA));
        check("kind_eom",   32'(frame_kind(FR_EOM)), 32'(K_EOM));
        check("kind_bad",   32'(frame_kind(FR_BAD)), 32'(K_BAD));
        reset = 1'b0;

        // Lock on a 5-symbol offset stream
        idle(5);
        send_frame(FR_AB, 1'b0);
        send_frame(FR_AB, 1'b0);
        check("lock_before_2nd_out", 32'(o_locked), 32'd0);
        check("no_valid_yet", 32'(n_valid), 32'd0);
        send_frame(FR_AB, 1'b0);
        check("first_valid", 32'(n_valid), 32'd1);
        check("locked_up", 32'(o_locked), 32'd1);
        check("i_ab", 32'(o_i), 32'h0ABC);
        check("q_ab", 32'(o_q), 32'h1234);
        send_frame(FR_AB, 1'b0);
        check("second_valid", 32'(n_valid), 32'd2);

        // End-of-message while locked
        send_frame(FR_EOM, 1'b0);
        send_frame(FR_AB, 1'b0);
        check("eom_count", 32'(n_eom), 32'd1);
        check("valid_after_eom", 32'(n_valid), 32'd3);
        check("i_hold", 32'(o_i), 32'h0ABC);
        check("q_hold", 32'(o_q), 32'h1234);

        // Two bad frames then good, then three bad frames
        send_frame(FR_BAD, 1'b0);
        send_frame(FR_BAD, 1'b0);
        send_frame(FR_AB, 1'b0);
        check("err_two", 32'(o_err_cnt), 32'd2);
        check("model_err_two", 32'(m_err), 32'd2);
        check("still_locked", 32'(o_locked), 32'd1);
        send_frame(FR_BAD, 1'b0);
        send_frame(FR_BAD, 1'b0);
        send_frame(FR_BAD, 1'b0);
        idle(2);
        check("err_five", 32'(o_err_cnt), 32'd5);
        check("lost_lock", 32'(o_locked), 32'd0);

        // Relock on a second pattern, then transmitter goes idle
        idle(20);
        send_frame(FR_FF, 1'b0);
        send_frame(FR_FF, 1'b0);
        send_frame(FR_FF, 1'b0);
        check("relock", 32'(o_locked), 32'd1);
        check("i_ff", 32'(o_i), 32'h1FFF);
        check("q_ff", 32'(o_q), 32'h0001);
        v0 = n_valid;
        idle(40);
        check("idle_unlock", 32'(o_locked), 32'd0);
        check("idle_err", 32'(o_err_cnt), 32'd5);
        check("idle_pulses", 32'(n_valid - v0), 32'd1);

        // Saturate the error counter over repeated relocks
        for (int r = 0; r < 90; r++) begin
            idle(16);
            send_frame(FR_AB, 1'b0);
            send_frame(FR_AB, 1'b0);
            send_frame(FR_BAD, 1'b0);
            send_frame(FR_BAD, 1'b0);
            send_frame(FR_BAD, 1'b0);
        end
        idle(2);
        check("err_sat", 32'(o_err_cnt), 32'd255);
        check("model_err_sat", 32'(m_err), 32'd255);

        // Clear coincident with a bad-frame increment
        idle(16);
        send_frame(FR_AB, 1'b0);
        send_frame(FR_AB, 1'b0);
        send_frame(FR_BAD, 1'b0);
        send_frame(FR_AB, 1'b1);
        check("err_cleared", 32'(o_err_cnt), 32'd0);
        check("locked_after_clear", 32'(o_locked), 32'd1);

        // Asynchronous reset seven clocks into a locked frame
        for (int k = 0; k < 7; k++) send_pair({FR_AB[30 - 2*k], FR_AB[31 - 2*k]});
        reset = 1'b1;
        rx_d = 2'b00;
        #1;
        check("arst_locked", 32'(o_locked), 32'd0);
        check("arst_i", 32'(o_i), 32'd0);
        check("arst_q", 32'(o_q), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        v0 = n_valid;
        idle(16);
        send_frame(FR_AB, 1'b0);
        send_frame(FR_AB, 1'b0);
        check("post_rst_no_valid", 32'(n_valid - v0), 32'd0);
        check("post_rst_unlocked", 32'(o_locked), 32'd0);
        send_frame(FR_AB, 1'b0);
        check("post_rst_valid", 32'(n_valid - v0), 32'd1);
        check("post_rst_locked", 32'(o_locked), 32'd1);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
